cbd_stream_sampler: RTL
=======================

Name: cbd_stream_sampler

Overview:
Consumer end of the PRF squeeze stream for the Kyber sampler path. Accepts 64-bit little-endian PRF words over a valid/ready handshake and applies centred-binomial sampling with eta = 3 (eta1) or eta = 2 (eta2). Emits one polynomial of 256 coefficients, one per cycle, over a valid/ready output stream. Sits between the SHAKE256 PRF core and the polynomial RAM writer, in place of the fixed-buffer sampler when the PRF output is streamed.

Parameters:
N_COEFF, 256, coefficients per polynomial.
Q, 3329, modulus; used only when CBD_MODQ_EN is defined.
ETA1, 3, eta selected by eta_i = 0.
ETA2, 2, eta selected by eta_i = 1.

Ports:
clk_i  input  1  clock, rising edge.
rst_n_i  input  1  asynchronous reset, active low.
run_i  input  1  start pulse; sampled only in IDLE.
eta_i  input  1  0: eta1 (3), 1: eta2 (2); latched on run_i.
word_i  input  64  PRF word; byte 0 in [7:0]; bits consumed LSB first.
word_valid_i  input  1  word_i valid.
word_ready_o  output  1  sampler accepts word_i this cycle.
coeff_o  output  12  sampled coefficient (format below).
coeff_idx_o  output  8  index 0..255 of coeff_o.
coeff_valid_o  output  1  coeff_o valid.
coeff_ready_i  input  1  downstream accepts coeff_o.
busy_o  output  1  high in RUN.
done_o  output  1  one-cycle pulse after coefficient 255 is accepted.

Behaviour:
- Reset (async, rst_n_i = 0): state IDLE; bit buffer, fill count, word count and coefficient index all 0. Outputs word_ready_o = 0, coeff_valid_o = 0, coeff_o = 0, coeff_idx_o = 0, busy_o = 0, done_o = 0. Reset mid-RUN discards all partial data.
- FSM:
  - IDLE -> RUN on run_i: latch eta (e = 3 or 2); clear buffer, fill, word count and index.
  - RUN -> DONE when coefficient 255 handshakes.
  - DONE -> IDLE next cycle; done_o = 1 for that one DONE cycle.
  - run_i is ignored in RUN and DONE.
- Buffer: 128-bit shift register with 8-bit fill count. Words required W = 64*e/8: 24 for eta = 3, 16 for eta = 2.
- word_ready_o = RUN and fill <= 64 and words_accepted < W. The new word is appended at bit position fill.
- coeff_valid_o = RUN and fill >= 2e. Output is combinational from buffer bits [2e-1:0]:
  - a = popcount of bits [e-1:0]
  - b = popcount of bits [2e-1:e]
  - value = a - b, range -3..3
- Consume on coeff_valid_o and coeff_ready_i: shift buffer right by 2e, advance index.
- Accept and consume in the same cycle are legal: fill_next = fill + 64*acc - 2e*cons. Accept is decided on the current fill.
- Latency: the first coeff_valid_o comes the cycle after the first word is accepted. With the stream unstalled the sampler sustains 1 coefficient/cycle.
- Exact bit budget: W*64 = 256*2e, so fill = 0 at DONE. No leftover bits and no extra words are accepted.
- Upstream stall (word_valid_i = 0) or downstream stall: all state holds. coeff_o and coeff_idx_o stay stable while valid and not ready.
- Without CBD_MODQ_EN, coeff_o is the 3-bit two's-complement value sign-extended to 12 bits (-1 = 12'hFFF).

Optional Feature:
- Macro CBD_MODQ_EN.
- Defined: coeff_o is canonical mod Q in [0, 3328]; negative v maps to Q + v (-1 -> 3328, -3 -> 3326). The mapping is combinational and latency is unchanged.
- Undefined: sign-extended two's complement as above.

Decomposition:
- Shared package (FUNCS or the Kyber package) holds:
  - constants N_COEFF, Q, ETA1, ETA2
  - typedef coeff_t (logic [11:0])
  - FSM enum state_t {IDLE, RUN, DONE}
  - function cbd_coeff(bits, eta), returning the signed value
- One natural sub-module: cbd_unit, combinational, (bits[5:0], eta) -> signed 3-bit, plus the mod-Q map under CBD_MODQ_EN.
- The top holds the FSM, buffer and handshakes.

Test Plan:
1. eta_i = 0, first word 64'h9d34be314d06e57d (PRF bytes 7d e5 06 4d ...) -> first coefficients -1, 1, 0, 1 (12'hFFF, 1, 0, 1; with CBD_MODQ_EN: 3328, 1, 0, 1).
2. eta_i = 0, full 192-byte PRF N=0 stream for seed 0x98536d...6885, no stalls -> 256 coefficients matching the golden N=0 vector; exactly 24 words accepted; done_o pulses once; fill = 0.
3. eta_i = 1, first byte 0x7d -> coefficients -1, 1. A full 128-byte stream -> exactly 16 words accepted, then word_ready_o stays 0 while word_valid_i is held high.
4. Random word_valid_i / coeff_ready_i throttling on scenario 2 -> identical coefficient sequence; coeff_o and coeff_idx_o stable under backpressure; no overflow (fill <= 128).
5. rst_n_i low at coefficient 100 -> all outputs 0 immediately. A new run_i then reproduces scenario 2 from index 0.
6. run_i pulsed during RUN -> ignored; index continues and a single done_o pulse occurs.

Source files
------------

// File: rtl/cbd_stream_sampler_pkg.sv
// Shared constants, types and the centred-binomial helper for the streaming CBD sampler.
// Optional mod-Q output mapping is enabled with CBD_MODQ_EN (see cbd_stream_sampler_cbd_unit).
package cbd_stream_sampler_pkg;

    localparam int N_COEFF = 256;
    localparam int Q       = 3329;
    localparam int ETA1    = 3;
    localparam int ETA2    = 2;

    typedef logic [11:0] coeff_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // eta_sel = 0 selects eta = 3 (bits [5:0]); eta_sel = 1 selects eta = 2 (bits [3:0]).
    function automatic logic signed [2:0] cbd_coeff(input logic [5:0] bits, input logic eta_sel);
        logic [1:0] a_s;
        logic [1:0] b_s;
        if (eta_sel) begin
            a_s = {1'b0, bits[0]} + {1'b0, bits[1]};
            b_s = {1'b0, bits[2]} + {1'b0, bits[3]};
        end else begin
            a_s = {1'b0, bits[0]} + {1'b0, bits[1]} + {1'b0, bits[2]};
            b_s = {1'b0, bits[3]} + {1'b0, bits[4]} + {1'b0, bits[5]};
        end
        return $signed({1'b0, a_s}) - $signed({1'b0, b_s});
    endfunction

endpackage

// File: rtl/cbd_stream_sampler_cbd_unit.sv
// Combinational CBD coefficient former: 6 buffer bits -> 12-bit coefficient.
// CBD_MODQ_EN selects canonical mod-Q output instead of sign-extended two's complement.
module cbd_stream_sampler_cbd_unit
    import cbd_stream_sampler_pkg::*;
(
    input  logic [5:0] bits,
    input  logic       eta_sel,
    output coeff_t     coeff
);

    logic signed [2:0] val_s;

`ifdef CBD_MODQ_EN
    localparam coeff_t Q_C = coeff_t'(Q);

    // Negative values wrap to Q + v; the 12-bit sum drops the sign-extension carry.
    always_comb begin
        val_s = cbd_coeff(bits, eta_sel);
        if (val_s[2]) begin
            coeff = Q_C + {{9{val_s[2]}}, val_s};
        end else begin
            coeff = {9'd0, val_s};
        end
    end
`else
    // Sign-extend the 3-bit difference to the coefficient width.
    always_comb begin
        val_s = cbd_coeff(bits, eta_sel);
        coeff = {{9{val_s[2]}}, val_s};
    end
`endif

endmodule

// File: rtl/cbd_stream_sampler.sv
// Streaming centred-binomial sampler: 64-bit PRF words in, 256 coefficients out.
// Build with CBD_MODQ_EN for canonical mod-Q coefficients.
module cbd_stream_sampler
    import cbd_stream_sampler_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        run_i,
    input  logic        eta_i,
    input  logic [63:0] word_i,
    input  logic        word_valid_i,
    output logic        word_ready_o,
    output coeff_t      coeff_o,
    output logic [7:0]  coeff_idx_o,
    output logic        coeff_valid_o,
    input  logic        coeff_ready_i,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [7:0] STEP1     = 8'(2 * ETA1);
    localparam logic [7:0] STEP2     = 8'(2 * ETA2);
    localparam logic [4:0] WORDS1    = 5'(N_COEFF * 2 * ETA1 / 64);
    localparam logic [4:0] WORDS2    = 5'(N_COEFF * 2 * ETA2 / 64);
    localparam logic [7:0] LAST_IDX  = 8'(N_COEFF - 1);

    state_t        state_r;
    state_t        state_s;
    logic          eta_r;
    logic          eta_s;
    logic [127:0]  buf_r;
    logic [127:0]  buf_s;
    logic [127:0]  shifted_s;
    logic [7:0]    fill_r;
    logic [7:0]    fill_s;
    logic [7:0]    fill_cons_s;
    logic [4:0]    words_r;
    logic [4:0]    words_s;
    logic [7:0]    idx_r;
    logic [7:0]    idx_s;
    logic [7:0]    step_s;
    logic [4:0]    words_max_s;
    logic          word_ready_s;
    logic          coeff_valid_s;
    logic          acc_s;
    logic          cons_s;

    // Handshake qualifiers derived from the current fill and word count.
    always_comb begin
        step_s        = eta_r ? STEP2 : STEP1;
        words_max_s   = eta_r ? WORDS2 : WORDS1;
        word_ready_s  = (state_r == RUN) && (fill_r <= 8'd64) && (words_r < words_max_s);
        coeff_valid_s = (state_r == RUN) && (fill_r >= step_s);
        acc_s         = word_ready_s && word_valid_i;
        cons_s        = coeff_valid_s && coeff_ready_i;
    end

    cbd_stream_sampler_cbd_unit u_cbd_unit (
        .bits    (buf_r[5:0]),
        .eta_sel (eta_r),
        .coeff   (coeff_o)
    );

    assign word_ready_o  = word_ready_s;
    assign coeff_valid_o = coeff_valid_s;
    assign coeff_idx_o   = idx_r;
    assign busy_o        = (state_r == RUN);
    assign done_o        = (state_r == DONE);

    // Next-state and buffer update; consume shifts first so the new word lands at the post-shift fill.
    always_comb begin
        state_s     = state_r;
        eta_s       = eta_r;
        buf_s       = buf_r;
        fill_s      = fill_r;
        words_s     = words_r;
        idx_s       = idx_r;
        shifted_s   = buf_r;
        fill_cons_s = fill_r;
        case (state_r)
            IDLE: begin
                if (run_i) begin
                    state_s = RUN;
                    eta_s   = eta_i;
                    buf_s   = 128'd0;
                    fill_s  = 8'd0;
                    words_s = 5'd0;
                    idx_s   = 8'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cons_s) begin
                    shifted_s   = buf_r >> step_s;
                    fill_cons_s = fill_r - step_s;
                    idx_s       = idx_r + 8'd1;
                end else begin
                    shifted_s   = buf_r;
                    fill_cons_s = fill_r;
                end
                if (acc_s) begin
                    buf_s   = shifted_s | ({64'd0, word_i} << fill_cons_s);
                    fill_s  = fill_cons_s + 8'd64;
                    words_s = words_r + 5'd1;
                end else begin
                    buf_s   = shifted_s;
                    fill_s  = fill_cons_s;
                end
                if (cons_s && (idx_r == LAST_IDX)) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= IDLE;
            eta_r   <= 1'b0;
            buf_r   <= 128'd0;
            fill_r  <= 8'd0;
            words_r <= 5'd0;
            idx_r   <= 8'd0;
        end else begin
            state_r <= state_s;
            eta_r   <= eta_s;
            buf_r   <= buf_s;
            fill_r  <= fill_s;
            words_r <= words_s;
            idx_r   <= idx_s;
        end
    end

endmodule
